// File: rtl/cic_pkg.sv
// Shared CIC receive-filter constants and the shift+saturate helper,
// also used by the demodulator interface.
package cic_pkg;

    localparam int unsigned CIC_NDEC      = 40;
    localparam int unsigned CIC_NSTAGE    = 4;
    localparam int unsigned CIC_M         = 1;
    localparam int unsigned CIC_DEC_RATIO = 200;

    // Working width of the helper; wide enough for any NDEC plus a guard bit.
    localparam int unsigned SAT_W = 64;

    typedef struct packed {
        logic             clip;
        logic [SAT_W-1:0] val;
    } sat_res_t;

    // Arithmetic right shift, then clamp to a signed out_w-bit range.
    function automatic sat_res_t sat_trunc(
        input logic signed [SAT_W-1:0] x,
        input int unsigned             shift,
        input int unsigned             out_w
    );
        sat_res_t                r;
        logic signed [SAT_W-1:0] s;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        s  = x >>> shift;
        hi = (SAT_W'(1) <<< (out_w - 1)) - SAT_W'(1);
        lo = ~hi;
        r.clip = (s > hi) || (s < lo);
        if (s > hi) begin
            r.val = hi;
        end else if (s < lo) begin
            r.val = lo;
        end else begin
            r.val = s;
        end
        return r;
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC differentiator: y = x - x[n-M] modulo 2^NDEC, state advances
// only on input valid; vout is the one-cycle-delayed input valid.
module cic_comb_stage
    import cic_pkg::*;
#(
    parameter int unsigned NDEC = CIC_NDEC,
    parameter int unsigned M    = CIC_M
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            vin,
    input  logic [NDEC-1:0] xin,
    output logic            vout,
    output logic [NDEC-1:0] yout
);

    logic [NDEC-1:0] dly_q [M];
    logic [NDEC-1:0] dly_d [M];
    logic [NDEC-1:0] y_q;
    logic [NDEC-1:0] y_d;
    logic            v_q;

    // Difference and delay-line shift, both gated by vin.
    always_comb begin
        dly_d = dly_q;
        y_d   = y_q;
        if (vin) begin
            y_d      = xin - dly_q[M-1];
            dly_d[0] = xin;
            for (int unsigned i = 1; i < M; i++) begin
                dly_d[i] = dly_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < M; i++) begin
                dly_q[i] <= '0;
            end
            y_q <= '0;
            v_q <= 1'b0;
        end else begin
            dly_q <= dly_d;
            y_q   <= y_d;
            v_q   <= vin;
        end
    end

    assign vout = v_q;
    assign yout = y_q;

endmodule

// File: rtl/cic_comb.sv
// CIC comb section: NSTAGE differentiators, then shift/saturate to DOUT_W.
// Define CIC_COMB_ROUND_EN for round-half-up instead of floor before saturation.
module cic_comb
    import cic_pkg::*;
#(
    parameter int unsigned NDEC      = CIC_NDEC,
    parameter int unsigned NSTAGE    = CIC_NSTAGE,
    parameter int unsigned M         = CIC_M,
    parameter int unsigned DOUT_W    = 16,
    parameter int unsigned OUT_SHIFT = 24
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     en,
    input  logic                     din_valid,
    input  logic signed [NDEC-1:0]   din,
    output logic                     dout_valid,
    output logic signed [DOUT_W-1:0] dout,
    output logic                     ovf
);

    localparam int unsigned EXT_W = NDEC + 1;

`ifdef CIC_COMB_ROUND_EN
    localparam logic [EXT_W-1:0] HALF = (OUT_SHIFT == 0) ? '0 : EXT_W'(1) << (OUT_SHIFT - 1);
`else
    localparam logic [EXT_W-1:0] HALF = '0;
`endif

    logic [NDEC-1:0] stage_x [NSTAGE+1];
    logic [NSTAGE:0] stage_v;

    assign stage_x[0] = din;
    assign stage_v[0] = din_valid & en;

    for (genvar g = 0; g < NSTAGE; g++) begin : g_stage
        cic_comb_stage #(
            .NDEC (NDEC),
            .M    (M)
        ) u_stage (
            .clk  (clk),
            .rstn (rstn),
            .vin  (stage_v[g]),
            .xin  (stage_x[g]),
            .vout (stage_v[g+1]),
            .yout (stage_x[g+1])
        );
    end

    logic signed [EXT_W-1:0]  ext_s;
    sat_res_t                 sat;
    logic                     unused_sat_hi;
    logic signed [DOUT_W-1:0] dout_q;
    logic signed [DOUT_W-1:0] dout_d;
    logic                     dout_valid_q;
    logic                     ovf_q;
    logic                     ovf_d;

    // Guard bit keeps the rounding add from wrapping; shift/clamp follow.
    always_comb begin
        ext_s = {stage_x[NSTAGE][NDEC-1], stage_x[NSTAGE]} + HALF;
        sat   = sat_trunc(SAT_W'(ext_s), OUT_SHIFT, DOUT_W);
    end

    assign unused_sat_hi = ^sat.val[SAT_W-1:DOUT_W];

    always_comb begin
        dout_d = dout_q;
        ovf_d  = ovf_q;
        if (stage_v[NSTAGE]) begin
            dout_d = DOUT_W'(sat.val);
            ovf_d  = ovf_q | sat.clip;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            dout_q       <= dout_d;
            dout_valid_q <= stage_v[NSTAGE];
            ovf_q        <= ovf_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_cic_comb.sv
// Bench for cic_comb: four configurations share one stimulus stream; a
// binomial-sum reference model and table constants feed per-DUT scoreboards.
module tb_cic_comb;

    localparam int NDUT = 4;
`ifdef CIC_COMB_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               en = 1'b0;
    logic               din_valid = 1'b0;
    logic signed [39:0] din = '0;

    logic signed [39:0] dout_a;
    logic signed [15:0] dout_b;
    logic signed [39:0] dout_c;
    logic signed [15:0] dout_d;
    logic               dv_a, dv_b, dv_c, dv_d;
    logic               ov_a, ov_b, ov_c, ov_d;

    always #5 clk = ~clk;

    cic_comb #(.NDEC(40), .NSTAGE(4), .M(1), .DOUT_W(40), .OUT_SHIFT(0)) u_a (
        .clk(clk), .rstn(rstn), .en(en), .din_valid(din_valid), .din(din),
        .dout_valid(dv_a), .dout(dout_a), .ovf(ov_a));
    cic_comb #(.NDEC(40), .NSTAGE(1), .M(1), .DOUT_W(16), .OUT_SHIFT(24)) u_b (
        .clk(clk), .rstn(rstn), .en(en), .din_valid(din_valid), .din(din),
        .dout_valid(dv_b), .dout(dout_b), .ovf(ov_b));
    cic_comb #(.NDEC(40), .NSTAGE(1), .M(1), .DOUT_W(40), .OUT_SHIFT(0)) u_c (
        .clk(clk), .rstn(rstn), .en(en), .din_valid(din_valid), .din(din),
        .dout_valid(dv_c), .dout(dout_c), .ovf(ov_c));
    cic_comb #(.NDEC(40), .NSTAGE(2), .M(2), .DOUT_W(16), .OUT_SHIFT(20)) u_d (
        .clk(clk), .rstn(rstn), .en(en), .din_valid(din_valid), .din(din),
        .dout_valid(dv_d), .dout(dout_d), .ovf(ov_d));

    logic signed [63:0] dx [NDUT];
    logic [NDUT-1:0]    dv;
    logic [NDUT-1:0]    ov;
    assign dx[0] = 64'(dout_a);
    assign dx[1] = 64'(dout_b);
    assign dx[2] = 64'(dout_c);
    assign dx[3] = 64'(dout_d);
    assign dv    = {dv_d, dv_c, dv_b, dv_a};
    assign ov    = {ov_d, ov_c, ov_b, ov_a};

    function automatic int cfg_ns(input int d);
        case (d)
            0: return 4;
            3: return 2;
            default: return 1;
        endcase
    endfunction
    function automatic int cfg_m(input int d);
        return (d == 3) ? 2 : 1;
    endfunction
    function automatic int cfg_sh(input int d);
        case (d)
            1: return 24;
            3: return 20;
            default: return 0;
        endcase
    endfunction
    function automatic int cfg_w(input int d);
        return (d == 1 || d == 3) ? 16 : 40;
    endfunction

    typedef struct {
        longint val;
        bit     ovf;
        int     cyc;
    } exp_t;

    typedef struct {
        longint din;
        bit     en;
        int     sel;
        longint exp;
        bit     ovf;
        int     gap;
    } vec_t;

    exp_t   sb [NDUT][$];
    vec_t   tbl[$];
    longint hist [NDUT][9];
    bit     movf [NDUT];
    int     cyc = 0;
    int     n_chk = 0;
    int     n_err = 0;
    bit     done_req = 1'b0;
    bit     done_ack = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint wrap40(input longint v);
        logic signed [39:0] t;
        t = v[39:0];
        return 64'(t);
    endfunction

    function automatic longint binom(input int n, input int k);
        longint r = 1;
        for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
        return r;
    endfunction

    // Reference: y[n] = sum_j (-1)^j C(N,j) x[n-jM] over accepted samples, then scale.
    task automatic model_accept(input int d, input longint x, output longint y, output bit clip);
        longint acc, s, hi, lo;
        int ns, m, sh;
        ns = cfg_ns(d); m = cfg_m(d); sh = cfg_sh(d);
        for (int i = 8; i > 0; i--) hist[d][i] = hist[d][i-1];
        hist[d][0] = wrap40(x);
        acc = 0;
        for (int j = 0; j <= ns; j++) begin
            if (j % 2 == 1) acc = acc - binom(ns, j) * hist[d][j*m];
            else            acc = acc + binom(ns, j) * hist[d][j*m];
        end
        acc = wrap40(acc);
        if (RND && sh > 0) acc = acc + (64'sd1 <<< (sh - 1));
        s  = acc >>> sh;
        hi = (64'sd1 <<< (cfg_w(d) - 1)) - 1;
        lo = -hi - 1;
        clip = (s > hi) || (s < lo);
        y = (s > hi) ? hi : ((s < lo) ? lo : s);
    endtask

    task automatic flush_model();
        for (int d = 0; d < NDUT; d++) begin
            sb[d].delete();
            movf[d] = 1'b0;
            for (int i = 0; i < 9; i++) hist[d][i] = 0;
        end
    endtask

    // Drive one strobe; expectations go to the scoreboards at drive time.
    task automatic strobe(input longint x, input bit e, input int sel, input longint texp, input bit tovf);
        longint y;
        bit     c;
        exp_t   ent;
        @(posedge clk); #1;
        din = x[39:0];
        din_valid = 1'b1;
        en = e;
        if (e) begin
            for (int d = 0; d < NDUT; d++) begin
                model_accept(d, x, y, c);
                movf[d] = movf[d] | c;
                ent.cyc = cyc + cfg_ns(d) + 1;
                ent.val = (d == sel) ? texp : y;
                ent.ovf = (d == sel) ? tovf : movf[d];
                sb[d].push_back(ent);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            din_valid = 1'b0;
            en = 1'b1;
        end
    endtask

    task automatic add_vec(input longint x, input bit e, input int sel, input longint ex, input bit eo, input int gap);
        vec_t v;
        v.din = x; v.en = e; v.sel = sel; v.exp = ex; v.ovf = eo; v.gap = gap;
        tbl.push_back(v);
    endtask

    task automatic run_tbl();
        for (int i = 0; i < tbl.size(); i++) begin
            strobe(tbl[i].din, tbl[i].en, tbl[i].sel, tbl[i].exp, tbl[i].ovf);
            idle(tbl[i].gap);
        end
        tbl.delete();
        idle(10);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rstn = 1'b0;
        din_valid = 1'b0;
        flush_model();
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        en = 1'b1;
    endtask

    task automatic cmp(input string nm, input int d, input logic signed [63:0] act, input longint ex);
        n_chk++;
        if (act !== 64'(ex)) begin
            n_err++;
            $display("FAIL %s dut%0d cyc %0d got %0d expected %0d", nm, d, cyc, act, ex);
        end
    endtask

    // Monitor: reset values while rstn is low, otherwise scoreboard pops.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < NDUT; d++) begin
            if (!rstn) begin
                cmp("rst_dout", d, dx[d], 0);
                cmp("rst_valid", d, 64'(dv[d]), 0);
                cmp("rst_ovf", d, 64'(ov[d]), 0);
            end else if (dv[d]) begin
                if (sb[d].size() == 0) begin
                    cmp("unexpected_valid", d, 64'(dv[d]), 0);
                end else begin
                    e = sb[d].pop_front();
                    cmp("dout", d, dx[d], e.val);
                    cmp("ovf", d, 64'(ov[d]), 64'(e.ovf));
                    cmp("latency", d, 64'(cyc), 64'(e.cyc));
                end
            end else if (sb[d].size() != 0 && sb[d][0].cyc < cyc) begin
                e = sb[d].pop_front();
                cmp("missing_valid", d, 64'(cyc), 64'(e.cyc));
            end
        end
        if (done_req && !done_ack) begin
            for (int d = 0; d < NDUT; d++) cmp("drain", d, 64'(sb[d].size()), 0);
            done_ack = 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        flush_model();
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        en = 1'b1;

        // Impulse through the 4-stage comb: binomial coefficients.
        add_vec(1, 1, 0, 1, 0, 1);
        add_vec(0, 1, 0, -4, 0, 0);
        add_vec(0, 1, 0, 6, 0, 2);
        add_vec(0, 1, 0, -4, 0, 0);
        add_vec(0, 1, 0, 1, 0, 1);
        for (int i = 0; i < 5; i++) add_vec(0, 1, 0, 0, 0, i % 2);
        run_tbl();

        // Linear ramp on the single-stage, shift-24 instance.
        do_reset();
        for (int k = 0; k < 10; k++) add_vec(longint'(k) <<< 24, 1, 1, (k == 0) ? 0 : 1, 0, 0);
        run_tbl();

        // Modular wrap: +max then -min differs by exactly +1.
        do_reset();
        add_vec((64'sd1 <<< 39) - 1, 1, 2, (64'sd1 <<< 39) - 1, 0, 0);
        add_vec(-(64'sd1 <<< 39), 1, 2, 1, 0, 0);
        run_tbl();

        // Truncation versus rounding on the shift-24 instance.
        do_reset();
        add_vec(0, 1, 1, 0, 0, 0);
        add_vec(-1, 1, 1, RND ? 0 : -1, 0, 0);
        add_vec(0, 1, 1, 0, 0, 0);
        add_vec(0, 1, 1, 0, 0, 0);
        add_vec(3 * (64'sd1 <<< 23), 1, 1, RND ? 2 : 1, 0, 0);
        add_vec(0, 1, 1, RND ? -1 : -2, 0, 0);
        run_tbl();

        // Saturation on the 2-stage M=2 instance; ovf must stay set.
        do_reset();
        add_vec(0, 1, 3, 0, 0, 0);
        add_vec(64'sd1 <<< 38, 1, 3, 32767, 1, 0);
        add_vec(0, 1, 3, 0, 1, 0);
        add_vec(0, 1, 3, -32768, 1, 1);
        add_vec(0, 1, 3, 0, 1, 0);
        run_tbl();

        // Enable gating: strobes 5..7 blocked, differences skip them.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            if (i >= 5 && i <= 7) add_vec(10 * i, 0, 2, 0, 0, 0);
            else add_vec(10 * i, 1, 2, (i == 0) ? 0 : ((i == 8) ? 40 : 10), 0, 0);
        end
        run_tbl();

        // Random stream with random gaps and enables.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            strobe(longint'({$urandom(), $urandom()}), $urandom_range(0, 3) != 0, -1, 0, 0);
            idle($urandom_range(0, 2));
        end

        // Reset two cycles after a strobe: in-flight samples vanish.
        strobe(64'sd123456789, 1, -1, 0, 0);
        idle(2);
        rstn = 1'b0;
        flush_model();
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        idle(12);

        done_req = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
